// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access controller: FSM states, latched op bits
// and the byte sign-extension helper.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IND_RD  = 3'd1,
    IND_UPD = 3'd2,
    ACCESS  = 3'd3,
    HOLD    = 3'd4
  } lc3b_mem_state;

  typedef struct packed {
    logic read;
    logic write;
    logic indirect;
    logic byte_op;
  } lc3b_mem_op;

  function automatic logic [15:0] sext8_to_word(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_align.sv
// Byte-lane steering between the 16-bit datapath and the data cache:
// byte enables, replicated store data and sign-extended byte load extract.
module mem_byte_align
  import mem_access_unit_pkg::*;
(
  input  logic        byte_op,
  input  logic        lane,
  input  logic [15:0] store_data,
  input  logic [15:0] rdata,
  output logic [1:0]  byte_en,
  output logic [15:0] wdata,
  output logic [15:0] load_data
);

  always_comb begin
    byte_en   = 2'b11;
    wdata     = store_data;
    load_data = rdata;
    if (byte_op) begin
      // Store byte goes to both lanes; byte_en picks which one the cache keeps.
      byte_en   = lane ? 2'b10 : 2'b01;
      wdata     = {store_data[7:0], store_data[7:0]};
      load_data = sext8_to_word(lane ? rdata[15:8] : rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs loads/stores (incl. byte and indirect forms) against
// the data cache and stalls EX/MEM and upstream until the access retires.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit ALIGN_WORD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   mem_addr_in,
  input  logic [15:0]   store_data_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic          indirect_in,
  input  logic          byte_op_in,
  input  logic          pipe_advance,
  input  logic          flush,
  input  logic [15:0]   dmem_rdata,
  input  logic          dmem_resp,
  output logic [15:0]   dmem_address,
  output logic          dmem_read,
  output logic          dmem_write,
  output logic [1:0]    dmem_byte_en,
  output logic [15:0]   dmem_wdata,
  output logic          load_memaddr,
  output logic [15:0]   next_memaddr,
  output logic [15:0]   mem_data_out,
  output logic          stall,
  output lc3b_mem_state state_dbg
);

  // Cache handshake: dmem_read/dmem_write rise with the request and stay high,
  // unchanged, until the cycle dmem_resp pulses; that cycle completes it.

  lc3b_mem_state state_q, state_d;
  lc3b_mem_op    op_q;
  logic [15:0]   addr_q, data_q, next_memaddr_q, mem_data_q;
  logic          flush_pend_q, flush_pend_d;
  logic          op_req, flush_eff, issue;
  logic [15:0]   word_addr;
  logic [1:0]    lane_be;
  logic [15:0]   lane_wdata, lane_load;

  assign op_req    = mem_read_in | mem_write_in;
  assign flush_eff = flush | flush_pend_q;
  assign issue     = (state_q == IDLE) && op_req && !flush;
  assign word_addr = ALIGN_WORD ? {addr_q[15:1], 1'b0} : addr_q;

  mem_byte_align u_align (
    .byte_op    (op_q.byte_op),
    .lane       (addr_q[0]),
    .store_data (data_q),
    .rdata      (dmem_rdata),
    .byte_en    (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = 1'b0;
    stall        = 1'b0;
    load_memaddr = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 16'h0000;
    dmem_byte_en = 2'b00;
    dmem_wdata   = 16'h0000;
    case (state_q)
      IDLE: begin
        stall = rst_n & op_req & ~flush;
        if (issue) state_d = indirect_in ? IND_RD : ACCESS;
      end
      IND_RD: begin
        stall        = 1'b1;
        dmem_read    = 1'b1;
        dmem_address = word_addr;
        dmem_byte_en = 2'b11;
        if (dmem_resp) state_d = flush_eff ? IDLE : IND_UPD;
        else           flush_pend_d = flush_eff;
      end
      IND_UPD: begin
        stall        = 1'b1;
        load_memaddr = op_q.indirect & ~flush;
        state_d      = flush ? IDLE : ACCESS;
      end
      ACCESS: begin
        stall        = ~dmem_resp;
        dmem_read    = op_q.read;
        dmem_write   = op_q.write;
        dmem_address = op_q.byte_op ? addr_q : word_addr;
        dmem_byte_en = lane_be;
        dmem_wdata   = op_q.write ? lane_wdata : 16'h0000;
        // A squashed access still retires to IDLE; HOLD only protects a live one.
        if (dmem_resp) state_d = (flush_eff || pipe_advance) ? IDLE : HOLD;
        else           flush_pend_d = flush_eff;
      end
      HOLD: begin
        if (pipe_advance || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= '0;
      addr_q         <= 16'h0000;
      data_q         <= 16'h0000;
      next_memaddr_q <= 16'h0000;
      mem_data_q     <= 16'h0000;
      flush_pend_q   <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
      if (issue) begin
        addr_q       <= mem_addr_in;
        data_q       <= store_data_in;
        // Read and write together is illegal; the write wins.
        op_q.read    <= mem_read_in & ~mem_write_in;
        op_q.write   <= mem_write_in;
        op_q.indirect <= indirect_in;
        op_q.byte_op <= byte_op_in;
      end
      if ((state_q == IND_RD) && dmem_resp && !flush_eff) begin
        next_memaddr_q <= dmem_rdata;
        addr_q         <= dmem_rdata;
      end
      if ((state_q == ACCESS) && dmem_resp && !flush_eff && op_q.read) begin
        mem_data_q <= lane_load;
      end
    end
  end

  assign next_memaddr = next_memaddr_q;
  assign mem_data_out = mem_data_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle expectations from a transaction
// model, checked on every falling edge, plus literal pins on key results.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   mem_addr_in, store_data_in, dmem_rdata;
  logic          mem_read_in, mem_write_in, indirect_in, byte_op_in;
  logic          pipe_advance, flush, dmem_resp;
  logic [15:0]   dmem_address, dmem_wdata, next_memaddr, mem_data_out;
  logic          dmem_read, dmem_write, load_memaddr, stall;
  logic [1:0]    dmem_byte_en;
  lc3b_mem_state state_dbg;

  mem_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr_in   (mem_addr_in),
    .store_data_in (store_data_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .indirect_in   (indirect_in),
    .byte_op_in    (byte_op_in),
    .pipe_advance  (pipe_advance),
    .flush         (flush),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_byte_en  (dmem_byte_en),
    .dmem_wdata    (dmem_wdata),
    .load_memaddr  (load_memaddr),
    .next_memaddr  (next_memaddr),
    .mem_data_out  (mem_data_out),
    .stall         (stall),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic          e_read, e_write, e_load, e_stall;
  logic [15:0]   e_addr, e_wdata, e_mem_data, e_next;
  logic [1:0]    e_be;
  lc3b_mem_state e_state;
  logic [15:0]   exp_q[$];
  logic [15:0]   last_wdata;
  logic [1:0]    last_be;
  int            n_vec = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

  function automatic logic [15:0] lane_data(input logic [15:0] d);
    return {d[7:0], d[7:0]};
  endfunction

  function automatic logic [15:0] ldb_value(input logic [15:0] a, input logic [15:0] r);
    logic [7:0] b;
    b = a[0] ? r[15:8] : r[7:0];
    return b[7] ? (16'hFF00 | {8'h00, b}) : {8'h00, b};
  endfunction

  task automatic idle_exp();
    e_read  = 1'b0;
    e_write = 1'b0;
    e_load  = 1'b0;
    e_stall = 1'b0;
    e_state = IDLE;
  endtask

  always @(negedge clk) begin
    chk("stall", 16'(stall), 16'(e_stall));
    chk("dmem_read", 16'(dmem_read), 16'(e_read));
    chk("dmem_write", 16'(dmem_write), 16'(e_write));
    chk("load_memaddr", 16'(load_memaddr), 16'(e_load));
    chk("state", 16'(state_dbg), 16'(e_state));
    chk("mem_data_out", mem_data_out, e_mem_data);
    chk("next_memaddr", next_memaddr, e_next);
    if (e_read || e_write) begin
      chk("dmem_address", dmem_address, e_addr);
      chk("dmem_byte_en", 16'(dmem_byte_en), 16'(e_be));
    end
    if (e_write) chk("dmem_wdata", dmem_wdata, e_wdata);
    if (dmem_write) begin
      last_wdata = dmem_wdata;
      last_be    = dmem_byte_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    indirect_in  = 1'b0;
    byte_op_in   = 1'b0;
  endtask

  // One complete instruction: issue, optional pointer fetch, access, optional HOLD.
  task automatic run_op(input logic rd, input logic wr, input logic ind, input logic bo,
                        input logic [15:0] addr, input logic [15:0] data,
                        input logic [15:0] ptr, input logic [15:0] rdata,
                        input int ptr_lat, input int lat, input int hold);
    logic [15:0] ea;
    ea = ind ? ptr : addr;
    if (rd && !wr) exp_q.push_back(bo ? ldb_value(ea, rdata) : rdata);
    mem_read_in = rd; mem_write_in = wr; indirect_in = ind; byte_op_in = bo;
    mem_addr_in = addr; store_data_in = data;
    flush = 1'b0; pipe_advance = 1'b1; dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    idle_exp();
    e_stall = 1'b1;
    step();
    if (ind) begin
      for (int k = 1; k <= ptr_lat; k++) begin
        dmem_resp  = (k == ptr_lat);
        dmem_rdata = (k == ptr_lat) ? ptr : 16'h0000;
        e_state = IND_RD; e_read = 1'b1; e_write = 1'b0; e_load = 1'b0; e_stall = 1'b1;
        e_addr  = word_of(addr); e_be = 2'b11;
        step();
      end
      dmem_resp = 1'b0;
      e_next  = ptr;
      e_state = IND_UPD; e_read = 1'b0; e_load = 1'b1; e_stall = 1'b1;
      step();
      e_load = 1'b0;
    end
    for (int k = 1; k <= lat; k++) begin
      dmem_resp    = (k == lat);
      dmem_rdata   = (k == lat) ? rdata : 16'h0000;
      pipe_advance = (k == lat) ? (hold == 0) : 1'b1;
      e_state = ACCESS; e_read = rd & ~wr; e_write = wr; e_stall = (k != lat);
      e_addr  = bo ? ea : word_of(ea);
      e_be    = bo ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
      e_wdata = bo ? lane_data(data) : data;
      step();
    end
    dmem_resp = 1'b0;
    if (rd && !wr) e_mem_data = exp_q.pop_front();
    for (int h = 1; h <= hold; h++) begin
      pipe_advance = (h == hold);
      idle_exp();
      e_state = HOLD;
      step();
    end
    pipe_advance = 1'b1;
    clear_ops();
    idle_exp();
    step();
  endtask

  // Load squashed while its request is outstanding; pipe_advance held low on purpose.
  task automatic run_flushed(input logic ind, input logic [15:0] addr,
                             input logic [15:0] rdata, input int lat);
    mem_read_in = 1'b1; mem_write_in = 1'b0; indirect_in = ind; byte_op_in = 1'b0;
    mem_addr_in = addr; flush = 1'b0; pipe_advance = 1'b1; dmem_resp = 1'b0;
    idle_exp();
    e_stall = 1'b1;
    step();
    for (int k = 1; k <= lat; k++) begin
      flush = (k == 1);
      if (k >= 2) clear_ops();
      pipe_advance = 1'b0;
      dmem_resp  = (k == lat);
      dmem_rdata = rdata;
      e_state = ind ? IND_RD : ACCESS; e_read = 1'b1; e_write = 1'b0; e_load = 1'b0;
      e_stall = ind ? 1'b1 : (k != lat);
      e_addr  = word_of(addr); e_be = 2'b11;
      step();
    end
    flush = 1'b0; dmem_resp = 1'b0; pipe_advance = 1'b1;
    clear_ops();
    idle_exp();
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_ops();
    mem_addr_in = 16'h0000; store_data_in = 16'h0000;
    pipe_advance = 1'b1; flush = 1'b0; dmem_rdata = 16'h0000; dmem_resp = 1'b0;
    idle_exp();
    e_addr = 16'h0000; e_wdata = 16'h0000; e_be = 2'b00;
    e_mem_data = 16'h0000; e_next = 16'h0000;
    last_wdata = 16'h0000; last_be = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: LDR, cache answers in the third request cycle
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hBEEF, 0, 3, 0);
    chk("ldr_result", mem_data_out, 16'hBEEF);

    // 2: STB high lane, LDB high lane negative, LDB low lane positive, STR odd address
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h2001, 16'h00A5, 16'h0000, 16'h0000, 0, 2, 0);
    chk("stb_wdata", last_wdata, 16'hA5A5);
    chk("stb_byte_en", 16'(last_be), 16'h0002);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h2001, 16'h0000, 16'h0000, 16'h8000, 0, 1, 0);
    chk("ldb_result", mem_data_out, 16'hFF80);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h2000, 16'h0000, 16'h0000, 16'h127F, 0, 2, 0);
    chk("ldb_lo_result", mem_data_out, 16'h007F);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h2003, 16'hCAFE, 16'h0000, 16'h0000, 0, 1, 0);
    chk("str_wdata", last_wdata, 16'hCAFE);

    // 3: LDI and STI
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 16'h4002, 16'h1234, 2, 2, 0);
    chk("ldi_ptr", next_memaddr, 16'h4002);
    chk("ldi_result", mem_data_out, 16'h1234);
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h3100, 16'hBEAD, 16'h4100, 16'h0000, 1, 1, 0);

    // both read and write set: treated as a write, load result untouched
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h1111, 16'h0000, 16'hFFFF, 0, 1, 0);

    // 4: response while downstream holds -> HOLD for three cycles, no re-issue
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0F0F, 0, 2, 3);
    chk("hold_result", mem_data_out, 16'h0F0F);

    // 5: flush during pointer fetch, during access, and at issue
    run_flushed(1'b1, 16'h5000, 16'h6000, 3);
    chk("flush_ind_ptr", next_memaddr, 16'h4100);
    run_flushed(1'b0, 16'h5100, 16'hDEAD, 2);
    chk("flush_acc_data", mem_data_out, 16'h0F0F);
    mem_read_in = 1'b1; mem_addr_in = 16'h5200; flush = 1'b1;
    idle_exp();
    step();
    flush = 1'b0;
    clear_ops();
    step();

    // 6: reset asserted in the middle of an access
    mem_read_in = 1'b1; mem_addr_in = 16'h7000;
    idle_exp();
    e_stall = 1'b1;
    step();
    e_state = ACCESS; e_read = 1'b1; e_stall = 1'b1; e_addr = 16'h7000; e_be = 2'b11;
    step();
    rst_n = 1'b0;
    clear_ops();
    idle_exp();
    e_mem_data = 16'h0000; e_next = 16'h0000;
    #1;
    chk("rst_dmem_read", 16'(dmem_read), 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0000);
    chk("rst_address", dmem_address, 16'h0000);
    chk("rst_byte_en", 16'(dmem_byte_en), 16'h0000);
    chk("rst_mem_data", mem_data_out, 16'h0000);
    chk("rst_next", next_memaddr, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h5A5A, 0, 1, 0);
    chk("post_rst_result", mem_data_out, 16'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
